// File: rtl/mux_arb_4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter with data mux.
package mux_arb_4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NUM_REQ      = 4;
    localparam int SEL_W        = 2;
    localparam int HOLD_W       = 4;
    localparam int MAX_HOLD_DEF = 4;

    typedef struct packed {
        logic             vld;
        logic [SEL_W-1:0] idx;
    } pick_t;

endpackage

// File: rtl/mux_arb_4_mux.sv
// Plain 4:1 single-bit data select.
module mux_4_1
    import mux_arb_4_pkg::*;
(
    input  logic [SEL_W-1:0]   sel,
    input  logic [NUM_REQ-1:0] i,
    output logic               o
);

    assign o = i[sel];

endmodule

// File: rtl/mux_arb_4.sv
// Round-robin arbiter for four requesters with bounded hold time and a
// 4:1 data path steered by the current owner.
module mux_arb_4
    import mux_arb_4_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               q
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                mux_o;
    logic                others;
    pick_t               pk;

    // First asserted request scanning p, p+1, p+2, p+3; walking the
    // offsets downward lets the nearest hit overwrite farther ones.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] r,
                                      input logic [SEL_W-1:0]   p);
        pick_t            res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = p + SEL_W'(k);
            if (r[idx]) begin
                res.vld = 1'b1;
                res.idx = idx;
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        pk      = '0;
        others  = |(req & ~gnt_q);
        case (state_q)
            IDLE: begin
                pk = rr_pick(req, ptr_q);
                if (pk.vld) begin
                    state_d = GRANT;
                    gnt_d   = NUM_REQ'(1) << pk.idx;
                    sel_d   = pk.idx;
                    hold_d  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (req[sel_q]) begin
                    if (others && hold_q >= HOLD_MAX) begin
                        // Preempt: restart the scan just past the owner so it lands last.
                        ptr_d  = sel_q + SEL_W'(1);
                        pk     = rr_pick(req, sel_q + SEL_W'(1));
                        gnt_d  = NUM_REQ'(1) << pk.idx;
                        sel_d  = pk.idx;
                        hold_d = HOLD_W'(1);
                    end else if (hold_q < HOLD_MAX) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    ptr_d = sel_q + SEL_W'(1);
                    pk    = rr_pick(req, sel_q + SEL_W'(1));
                    if (pk.vld) begin
                        gnt_d  = NUM_REQ'(1) << pk.idx;
                        sel_d  = pk.idx;
                        hold_d = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mux_4_1 u_mux (
        .sel (sel_q),
        .i   (din),
        .o   (mux_o)
    );

    always_comb begin
        busy = (state_q == GRANT);
        q    = mux_o & busy;
    end

    assign gnt = gnt_q;
    assign sel = sel_q;

endmodule
